// File: rtl/fft_out_collector.sv
// Collects bit-reversed parallel-4 FFT output beats into a ping-pong buffer and
// streams each frame out one complex sample per cycle in natural bin order.
module fft_out_collector #(
   parameter int NBITS_OUT = 15,
   parameter int N         = 128,
   parameter int LOG2N     = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*NBITS_OUT-1:0] fftOut0_up,
   input  logic [2*NBITS_OUT-1:0] fftOut0_down,
   input  logic [2*NBITS_OUT-1:0] fftOut1_up,
   input  logic [2*NBITS_OUT-1:0] fftOut1_down,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [2*NBITS_OUT-1:0] out_data,
   output logic [LOG2N-1:0]       out_idx,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   overflow_err,
   output logic [1:0]             dbgState
);

   // Handshakes: a beat moves on a rising edge where in_valid && in_ready; a
   // sample moves where out_valid && out_ready. out_valid never drops and the
   // output word never changes while out_valid && !out_ready.

   localparam int W  = 2*NBITS_OUT;
   localparam int KW = LOG2N-2;

   localparam logic [0:0] WR_FILL   = 1'b0;
   localparam logic [0:0] WR_WAIT   = 1'b1;
   localparam logic [0:0] RD_IDLE   = 1'b0;
   localparam logic [0:0] RD_STREAM = 1'b1;

   localparam logic [KW-1:0]    LAST_BEAT = {KW{1'b1}};
   localparam logic [KW-1:0]    BEAT_ONE  = 1;
   localparam logic [LOG2N-1:0] LAST_ADDR = {LOG2N{1'b1}};
   localparam logic [LOG2N-1:0] ADDR_ONE  = 1;

   logic [W-1:0]       mem [2*N];
   logic [0:0]         wrState;
   logic [0:0]         rdState;
   logic               wbank;
   logic               rbank;
   logic [1:0]         full;
   logic [1:0]         fullNext;
   logic [KW-1:0]      beatCnt;
   logic [LOG2N-1:0]   rdAddr;
   logic               accept;
   logic               frameDone;
   logic               rdLoad;
   logic               rdDone;

   function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   assign in_ready  = (wrState == WR_FILL) && !full[wbank];
   assign accept    = in_valid && in_ready;
   assign frameDone = accept && (beatCnt == LAST_BEAT);
   assign rdLoad    = (rdState == RD_STREAM) && (!out_valid || out_ready);
   assign rdDone    = rdLoad && (rdAddr == LAST_ADDR);
   assign dbgState  = {rdState, wrState};

   // Set and clear always target different banks, so both apply together.
   always_comb begin
      fullNext = full;
      if (frameDone) fullNext[wbank] = 1'b1;
      if (rdDone)    fullNext[rbank] = 1'b0;
   end

   // Lane l of beat k lands at bin bitrev(4k+l); all four in one cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[{wbank, bitRev({beatCnt, 2'd0})}] <= fftOut0_up;
         mem[{wbank, bitRev({beatCnt, 2'd1})}] <= fftOut0_down;
         mem[{wbank, bitRev({beatCnt, 2'd2})}] <= fftOut1_up;
         mem[{wbank, bitRev({beatCnt, 2'd3})}] <= fftOut1_down;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrState <= WR_FILL;
         wbank   <= 1'b0;
         beatCnt <= '0;
         full    <= 2'b00;
      end else begin
         full <= fullNext;
         case (wrState)
            WR_FILL: begin
               if (accept) begin
                  beatCnt <= beatCnt + BEAT_ONE;
                  if (frameDone) begin
                     beatCnt <= '0;
                     wbank   <= ~wbank;
                     if (fullNext[~wbank]) wrState <= WR_WAIT;
                  end
               end
            end
            default: begin
               if (!full[wbank]) wrState <= WR_FILL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdState   <= RD_IDLE;
         rbank     <= 1'b0;
         rdAddr    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else begin
         if (rdLoad) begin
            out_data  <= mem[{rbank, rdAddr}];
            out_idx   <= rdAddr;
            out_last  <= (rdAddr == LAST_ADDR);
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (rdState)
            RD_IDLE: begin
               if (full[rbank]) begin
                  rdState <= RD_STREAM;
                  rdAddr  <= '0;
               end
            end
            default: begin
               if (rdLoad) begin
                  rdAddr <= rdAddr + ADDR_ONE;
                  if (rdDone) begin
                     rbank   <= ~rbank;
                     rdState <= RD_IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       overflow_err <= 1'b0;
      else if (in_valid && !in_ready) overflow_err <= 1'b1;
   end

endmodule
